// File: rtl/sm_frame_pkg.sv
// Shared slot numbering and b/phase types for the 8-slot frame initiator and responder.
// Expected-outp helpers use b_t bit order: b_t[0]=b[1], b_t[1]=b[2], b_t[2]=b[3].
package sm_frame_pkg;
   typedef logic [2:0] phase_t;
   typedef logic [2:0] b_t;

   localparam phase_t SLOT0 = 3'd0;
   localparam phase_t SLOT1 = 3'd1;
   localparam phase_t SLOT2 = 3'd2;
   localparam phase_t SLOT3 = 3'd3;
   localparam phase_t SLOT4 = 3'd4;
   localparam phase_t SLOT5 = 3'd5;
   localparam phase_t SLOT6 = 3'd6;
   localparam phase_t SLOT7 = 3'd7;

   localparam phase_t SLOT_SAMPLE_A = SLOT2;
   localparam phase_t SLOT_SAMPLE_B = SLOT3;
   localparam phase_t SLOT_BRANCH   = SLOT3;

   function automatic logic exp_slot_a(input b_t b);
      return b[2] & (b[0] | b[1]);
   endfunction

   function automatic logic exp_slot_b(input b_t b);
      return b[0] | b[1];
   endfunction
endpackage

// File: rtl/sm_cmd_fifo.sv
// Command FIFO, DEPTH x 3 bits; pop data is the registered head, no bypass.
// Push is ignored when full and pop is ignored when empty; push and pop may coincide.
module sm_cmd_fifo
   import sm_frame_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  b_t   push_dat,
   input  logic pop,
   output b_t   pop_dat,
   output logic full,
   output logic empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic        do_push, do_pop;
   b_t          mem_q [DEPTH];

   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage carries no reset; the pointers alone define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
   end
endmodule

// File: rtl/sm_frame_driver.sv
// Drives b[3:1] one command per 4/8-cycle frame, returns {outp@slot3, outp@slot2}; response 4 cycles after frame start.
// cmd_ready = !full; a response arriving while one is held unconsumed is dropped and sets overflow. Check logic: SM_FRAME_CHECK_EN.
module sm_frame_driver
   import sm_frame_pkg::*;
#(
   parameter int CMD_DEPTH = 2,
   parameter b_t IDLE_B    = 3'b000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_b,
   output logic [2:0] b,
   input  logic       outp,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [1:0] rsp_bits,
   output logic       rsp_long,
   output logic [2:0] phase,
   output logic       overflow,
   output logic       mismatch
);
   phase_t     phase_q, phase_d;
   b_t         b_q, b_d, fifo_dat;
   logic       cmd_active_q, cmd_active_d;
   logic       s2_q, s2_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic [1:0] rsp_bits_q, rsp_bits_d;
   logic       rsp_long_q, rsp_long_d;
   logic       overflow_q, overflow_d;
   logic       mismatch_q, mismatch_d;
   logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic       frame_wrap, samp_a, samp_b;

   assign fifo_push = cmd_valid & ~fifo_full;
   assign cmd_ready = ~fifo_full;

   sm_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (fifo_push),
      .push_dat (cmd_b),
      .pop      (fifo_pop),
      .pop_dat  (fifo_dat),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) phase_q <= SLOT0;
      else        phase_q <= phase_d;
   end

   // The long path is taken only when the currently driven b[2] is set.
   always_comb begin
      case (phase_q)
         SLOT_BRANCH: phase_d = b_q[1] ? SLOT4 : SLOT0;
         SLOT7:       phase_d = SLOT0;
         default:     phase_d = phase_q + 3'd1;
      endcase
   end

   always_comb begin
      frame_wrap = ((phase_q == SLOT_BRANCH) && !b_q[1]) || (phase_q == SLOT7);
      samp_a     = (phase_q == SLOT_SAMPLE_A);
      samp_b     = (phase_q == SLOT_SAMPLE_B);
      fifo_pop   = frame_wrap & ~fifo_empty;
   end

   always_comb begin
      b_d          = b_q;
      cmd_active_d = cmd_active_q;
      if (frame_wrap) begin
         b_d          = fifo_empty ? IDLE_B : fifo_dat;
         cmd_active_d = ~fifo_empty;
      end
      s2_d        = samp_a ? outp : s2_q;
      rsp_valid_d = rsp_valid_q;
      rsp_bits_d  = rsp_bits_q;
      rsp_long_d  = rsp_long_q;
      overflow_d  = overflow_q;
      if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
      // A consumed slot may be refilled on the very edge it drains.
      if (cmd_active_q && samp_b) begin
         if (!rsp_valid_q || rsp_ready) begin
            rsp_valid_d = 1'b1;
            rsp_bits_d  = {outp, s2_q};
            rsp_long_d  = b_q[1];
         end else begin
            overflow_d  = 1'b1;
         end
      end
`ifdef SM_FRAME_CHECK_EN
      mismatch_d = mismatch_q
                 | (samp_a && (outp != exp_slot_a(b_q)))
                 | (samp_b && (outp != exp_slot_b(b_q)));
`else
      mismatch_d = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_q          <= IDLE_B;
         cmd_active_q <= 1'b0;
         s2_q         <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_bits_q   <= 2'b00;
         rsp_long_q   <= 1'b0;
         overflow_q   <= 1'b0;
         mismatch_q   <= 1'b0;
      end else begin
         b_q          <= b_d;
         cmd_active_q <= cmd_active_d;
         s2_q         <= s2_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_bits_q   <= rsp_bits_d;
         rsp_long_q   <= rsp_long_d;
         overflow_q   <= overflow_d;
         mismatch_q   <= mismatch_d;
      end
   end

   assign b         = b_q;
   assign phase     = phase_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_bits  = rsp_bits_q;
   assign rsp_long  = rsp_long_q;
   assign overflow  = overflow_q;
   assign mismatch  = mismatch_q;
endmodule

// File: doc/sm_frame_driver.md
Name: sm_frame_driver

Overview:
- Initiator-side companion to the 8-slot `b`/`outp` frame state machine. It drives `b[3:1]` into that machine and collects its `outp` result.
- Accepts 3-bit commands over a valid/ready interface and buffers them in a small FIFO. Holds each command on `b` for one whole frame.
- Mirrors the responder's frame phase from reset. Samples `outp` in slots 2 and 3 and returns a per-command response.
- Sits between a host/test controller and the frame state machine. Both blocks share `clk` and `rst_n`.

Parameters:
- CMD_DEPTH, 2, command FIFO entries; power of two, at least 2.
- IDLE_B, 3'b000, value driven on `b` during frames with no command.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  FIFO can accept a command; equals !full.
- cmd_b  input  3  command value; bit i of `cmd_b` maps to `b[i+1]`.
- b  output  3  registered drive to the responder's `b[3:1]`.
- outp  input  1  responder's combinational output.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumed.
- rsp_bits  output  2  {outp sampled in slot 3, outp sampled in slot 2}.
- rsp_long  output  1  the frame took the 8-slot path.
- phase  output  3  current mirrored slot number, 0..7.
- overflow  output  1  sticky: a response was dropped.
- mismatch  output  1  sticky: outp differed from the expected value (optional feature).

Behaviour:
- Reset (asynchronous, while `rst_n` low):
  - phase=0, b=IDLE_B, FIFO empty.
  - cmd_active=0, rsp_valid=0, rsp_bits=0, rsp_long=0, overflow=0, mismatch=0.
  - Reset asserted mid-frame discards the in-flight command, buffered commands and any pending response.
- Phase sequence:
  - 0→1→2→3, then 3→4 if the currently driven `b[2]`=1, else 3→0.
  - 4→5→6→7→0.
  - Frame length is therefore 4 or 8 cycles.
- `b` update:
  - Changes only on the edge where phase goes to 0, so `b` is stable for the whole frame.
  - On that edge, if the FIFO is non-empty: pop the head into `b` and set cmd_active=1.
  - Otherwise: load IDLE_B and set cmd_active=0.
  - The first post-reset frame is always idle.
- Command FIFO:
  - Push when cmd_valid & cmd_ready.
  - Pop only on the phase→0 edge when non-empty.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - When full, cmd_ready=0 even if a pop occurs that cycle (no pass-through).
  - A push into an empty FIFO on the phase→0 edge is not popped until the next frame.
- Sampling:
  - s2 captures `outp` at the end of phase 2.
  - s3 captures `outp` at the end of phase 3.
- Response generation:
  - Applies only to frames with cmd_active=1; idle frames produce no response.
  - On the edge leaving phase 3: rsp_valid=1, rsp_bits={outp, s2}, rsp_long=b[2].
  - rsp_valid first rises 4 cycles after the frame's phase-0 edge.
  - Response fields hold until rsp_valid & rsp_ready.
- Response boundary cases:
  - New response while rsp_valid=1 and rsp_ready=0: the new response is dropped, overflow sets and stays set until reset.
  - New response in the same cycle as rsp_ready=1: the new response replaces the consumed one; rsp_valid stays 1.
- Minimum spacing between responses is 4 cycles.

Optional Feature:
- Macro: SM_FRAME_CHECK_EN.
- Defined:
  - Expected value in slot 2 = b[3]&(b[1]|b[2]); in slot 3 = b[1]|b[2].
  - Checked in all frames, including idle ones.
  - Any difference from the sampled `outp` sets mismatch (sticky until reset).
- Undefined: the check logic is absent and mismatch is tied to 0. The port list is identical in both builds.

Decomposition:
- Shared package `sm_frame_pkg`:
  - slot constants SLOT0..SLOT7 (3-bit);
  - SLOT_SAMPLE_A=2 and SLOT_SAMPLE_B=3;
  - SLOT_BRANCH=3;
  - a phase_t 3-bit typedef;
  - a b_t 3-bit typedef.
  - The responder reuses the same constants.
- One sub-module, `sm_cmd_fifo`: synchronous FIFO, CMD_DEPTH entries × 3 bits, full/empty flags, asynchronous active-low reset.
- Phase tracking, sampling and the response register stay in the top module.

Test Plan:
- Reset, no commands, 20 cycles → phase cycles 0,1,2,3,0… with b=000; rsp_valid stays 0; cmd_ready=1.
- Push cmd_b=3'b011 (b[2]=1, b[1]=1) during the first idle frame against a reference responder → b=011 from the first phase-0 edge after the idle frame; phase runs 0..7; rsp_valid=1 four cycles after that edge; rsp_bits=2'b10; rsp_long=1.
- Push 3'b101, then 3'b001, with rsp_ready=1 → responses rsp_bits=2'b11, rsp_long=0, then rsp_bits=2'b10, rsp_long=0; each frame is 4 cycles.
- Hold cmd_valid=1 with CMD_DEPTH=2 → cmd_ready drops after 2 pushes beyond the in-flight command; it reasserts one cycle after the next phase-0 pop.
- Hold rsp_ready=0 across two command frames → the first response is held, overflow=1 after the second; it stays 1 until rst_n is pulsed low.
- Assert rst_n low mid-frame at phase 5 → b=IDLE_B, phase=0, rsp_valid=0 immediately; with SM_FRAME_CHECK_EN, forcing outp=1 in slot 2 with b=000 → mismatch=1.
